mem_access_stage: RTL

Pipeline MEM stage of the five-stage RV32I core: takes the EX/MEM latch, drives the data-memory port (variable-latency req/ack), aligns store data into byte lanes and generates byte enables. It registers the MEM/WB latch consumed by the writeback load-extraction logic, which does the byte/half selection and sign extension. It stalls the front of the pipe while a memory access is outstanding and flags misaligned, illegal and timed-out accesses.

---
 rtl/mem_access_stage_pkg.sv | 25 ++
 rtl/mem_access_stage_if.sv | 32 +++
 rtl/mem_access_stage_store_align.sv | 57 +++++
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared opcode/funct3 constants and state/cause types for the RV32I MEM stage.
package riscv_mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } fault_cause_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack port shared by the MEM stage and the memory model.
interface mem_access_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_store_align.sv
// Combinational store lane alignment plus misalignment / illegal-funct3 detection.
module store_align
  import riscv_mem_pkg::*;
(
  input  logic        i_isLoad,
  input  logic        i_isStore,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_rs2,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  output logic        o_illegal
);

  // Lane enables and replicated data for stores; loads only get a legality check.
  always_comb begin
    o_be      = 4'b0000;
    o_wdata   = 32'h0;
    o_illegal = 1'b0;
    if (i_isLoad) begin
      case (i_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: o_illegal = 1'b0;
        default:                         o_illegal = 1'b1;
      endcase
    end else if (i_isStore) begin
      case (i_funct3)
        F3_B: begin
          o_be    = 4'b0001 << i_addrLo;
          o_wdata = {4{i_rs2[7:0]}};
        end
        F3_H: begin
          o_be    = 4'b0011 << i_addrLo;
          o_wdata = {2{i_rs2[15:0]}};
        end
        F3_W: begin
          o_be    = 4'b1111;
          o_wdata = i_rs2;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

  // Size is encoded in funct3[1:0]; byte accesses can sit on any lane.
  always_comb begin
    o_misaligned = 1'b0;
    if (i_isLoad || i_isStore) begin
      case (i_funct3[1:0])
        2'b01:   o_misaligned = i_addrLo[0];
        2'b10:   o_misaligned = (i_addrLo != 2'b00);
        default: o_misaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I pipeline MEM stage: drives the variable-latency data-memory port,
// stalls the front of the pipe while an access is outstanding and registers MEM/WB.
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EXMEM_valid,
  input  logic [6:0]          EXMEM_opcode,
  input  logic [2:0]          EXMEM_funct3,
  input  logic [31:0]         EXMEM_alu_result,
  input  logic [31:0]         EXMEM_rs2_data,
  input  logic [4:0]          EXMEM_rd,
  input  logic                EXMEM_reg_write,
  mem_access_stage_if.master  dmem,
  output logic                mem_stall,
  output logic                mem_fault,
  output logic [1:0]          mem_fault_cause,
  output logic                MEMWB_valid_out,
  output logic [6:0]          MEMWB_opcode_out,
  output logic [2:0]          MEMWB_funct3_out,
  output logic [31:0]         MEMWB_data_addr_out,
  output logic [31:0]         MEMWB_data_read,
  output logic [31:0]         MEMWB_reg_write_data_out,
  output logic [4:0]          MEMWB_rd_out,
  output logic                MEMWB_reg_write_out
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  // Abort fires in the WAIT cycle whose increment would bring the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mem_state_t   r_state;
  mem_state_t   w_nextState;
  logic [CNT_W-1:0] r_waitCnt;

  logic         w_isLoad;
  logic         w_isStore;
  logic         w_isMem;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic         w_misaligned;
  logic         w_illegal;
  logic         w_pending;
  logic         w_abort;
  logic         w_fmtFault;
  logic         w_req;
  logic         w_stall;
  logic         w_fault;
  fault_cause_t w_cause;

  assign w_isLoad  = (EXMEM_opcode == OP_LOAD);
  assign w_isStore = (EXMEM_opcode == OP_STORE);
  assign w_isMem   = EXMEM_valid & (w_isLoad | w_isStore);

  store_align u_storeAlign (
    .i_isLoad     (w_isLoad),
    .i_isStore    (w_isStore),
    .i_funct3     (EXMEM_funct3),
    .i_addrLo     (EXMEM_alu_result[1:0]),
    .i_rs2        (EXMEM_rs2_data),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: if (w_pending && !dmem.dmem_ack) w_nextState = WAIT;
      WAIT: if (dmem.dmem_ack || w_abort)    w_nextState = IDLE;
    endcase
  end

  // EX/MEM is held stable by the stall, so WAIT simply keeps re-deriving the port from it.
  // Gating with rst_n keeps the port quiet while reset is held, whatever EX/MEM shows.
  always_comb begin
    w_pending  = 1'b0;
    w_abort    = 1'b0;
    w_fmtFault = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_fmtFault = rst_n & w_isMem & (w_misaligned | w_illegal);
        w_pending  = rst_n & w_isMem & ~w_misaligned & ~w_illegal;
      end
      WAIT: begin
        w_pending = rst_n;
        w_abort   = rst_n & TIMEOUT_EN & ~dmem.dmem_ack & (r_waitCnt == CNT_LAST);
      end
    endcase
    w_req   = w_pending & ~w_abort;
    w_stall = w_pending & ~dmem.dmem_ack & ~w_abort;
    w_fault = w_fmtFault | w_abort;
    if (w_abort)                       w_cause = CAUSE_TIMEOUT;
    else if (w_fmtFault && w_illegal)  w_cause = CAUSE_ILLEGAL;
    else if (w_fmtFault)               w_cause = CAUSE_MISALIGN;
    else                               w_cause = CAUSE_NONE;
  end

  assign dmem.dmem_req    = w_req;
  assign dmem.dmem_we     = w_isStore;
  assign dmem.dmem_addr   = {EXMEM_alu_result[31:2], 2'b00};
  assign dmem.dmem_be     = w_be;
  assign dmem.dmem_wdata  = w_wdata;
  assign mem_stall        = w_stall;
  assign mem_fault        = w_fault;
  assign mem_fault_cause  = w_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (r_state == IDLE) begin
      r_waitCnt <= '0;
    end else begin
      r_waitCnt <= r_waitCnt + CNT_W'(1);
    end
  end

  // A stalled cycle writes a bubble so the eventual ack edge is the only real writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEMWB_valid_out          <= 1'b0;
      MEMWB_opcode_out         <= 7'h0;
      MEMWB_funct3_out         <= 3'h0;
      MEMWB_data_addr_out      <= 32'h0;
      MEMWB_data_read          <= 32'h0;
      MEMWB_reg_write_data_out <= 32'h0;
      MEMWB_rd_out             <= 5'h0;
      MEMWB_reg_write_out      <= 1'b0;
    end else if (w_stall || w_fault || !EXMEM_valid) begin
      MEMWB_valid_out     <= 1'b0;
      MEMWB_opcode_out    <= 7'h0;
      MEMWB_reg_write_out <= 1'b0;
    end else begin
      MEMWB_valid_out  <= 1'b1;
      MEMWB_opcode_out <= EXMEM_opcode;
      MEMWB_funct3_out <= EXMEM_funct3;
      MEMWB_rd_out     <= EXMEM_rd;
      if (w_isLoad) begin
        MEMWB_reg_write_out <= EXMEM_reg_write;
        MEMWB_data_addr_out <= EXMEM_alu_result;
        MEMWB_data_read     <= dmem.dmem_rdata;
      end else if (w_isStore) begin
        MEMWB_reg_write_out <= 1'b0;
        MEMWB_data_addr_out <= EXMEM_alu_result;
      end else begin
        MEMWB_reg_write_out      <= EXMEM_reg_write;
        MEMWB_reg_write_data_out <= EXMEM_alu_result;
      end
    end
  end

endmodule
